// File: rtl/tlb_cp0_ctrl_if.sv
// CPU-side bus of the TLB/CP0 controller: TLB instruction handshake plus
// the MTC0 write port and the MFC0 read port.
interface tlb_cp0_ctrl_if;
    logic        op_valid;
    logic [1:0]  op_type;
    logic        op_ready;
    logic        op_done;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;

    modport master (
        output op_valid, op_type, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        input  op_ready, op_done, mfc0_rdata
    );

    modport slave (
        input  op_valid, op_type, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        output op_ready, op_done, mfc0_rdata
    );
endinterface

// File: rtl/tlb_cp0_ctrl.sv
// TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) and CP0 TLB register file
// (Index, Random, EntryLo0, EntryLo1, EntryHi). One instruction at a time,
// IDLE -> EXEC -> DONE, with op_done pulsing in DONE.
// Optional macro TLB_WIRED_EN adds the Wired register (CP0 6) that bounds
// the Random range to [Wired, TLBNUM-1].
module tlb_cp0_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    tlb_cp0_ctrl_if.slave    cpu,
    input  logic             exc_tlb_we_i,
    input  logic [31:0]      exc_badvaddr_i,
    output logic [31:0]      cp0_entryhi_o,
    output logic [18:0]      tlb_s_vpn2_o,
    output logic [7:0]       tlb_s_asid_o,
    input  logic             tlb_s_found_i,
    input  logic [IDXW-1:0]  tlb_s_index_i,
    output logic             tlb_we_o,
    output logic [IDXW-1:0]  tlb_w_index_o,
    output logic [77:0]      tlb_w_entry_o,
    output logic [IDXW-1:0]  tlb_r_index_o,
    input  logic [77:0]      tlb_r_entry_i
);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [IDXW-1:0] RAND_TOP = IDXW'(TLBNUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              op_ready, op_done, tlb_we;

    logic              idx_p_q, idx_p_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   rand_q, rand_d;
    logic [18:0]       vpn2_q, vpn2_d;
    logic [7:0]        asid_q, asid_d;
    logic [25:0]       lo0_q, lo0_d;
    logic [25:0]       lo1_q, lo1_d;

    logic exec_tlbp, exec_tlbr;
    logic wr_index, wr_entryhi, wr_lo0, wr_lo1;
    logic unused_bits;

    assign exec_tlbp  = (state_q == S_EXEC) && (op_q == OP_TLBP);
    assign exec_tlbr  = (state_q == S_EXEC) && (op_q == OP_TLBR);
    assign wr_index   = cpu.mtc0_we && (cpu.mtc0_addr == 5'd0);
    assign wr_lo0     = cpu.mtc0_we && (cpu.mtc0_addr == 5'd2);
    assign wr_lo1     = cpu.mtc0_we && (cpu.mtc0_addr == 5'd3);
    assign wr_entryhi = cpu.mtc0_we && (cpu.mtc0_addr == 5'd10);
    assign unused_bits = ^exc_badvaddr_i[12:0];

    // FSM state register; op_type is captured on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_TLBP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // FSM next state: each of EXEC and DONE lasts a single cycle
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (cpu.op_valid && op_ready) begin
                    state_d = S_EXEC;
                    op_d    = cpu.op_type;
                end
            end
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; a TLB write is suppressed while reset is asserted
    always_comb begin
        op_ready = 1'b0;
        op_done  = 1'b0;
        tlb_we   = 1'b0;
        case (state_q)
            S_IDLE:  op_ready = !reset;
            S_EXEC:  tlb_we   = op_q[1] && !reset;
            S_DONE:  op_done  = 1'b1;
            default: ;
        endcase
    end

    // CP0 register next state with TLB results beating MTC0 writes
    always_comb begin
        idx_p_d = idx_p_q;
        idx_d   = idx_q;
        vpn2_d  = vpn2_q;
        asid_d  = asid_q;
        lo0_d   = lo0_q;
        lo1_d   = lo1_q;

        if (exec_tlbp) begin
            idx_p_d = !tlb_s_found_i;
            if (tlb_s_found_i) idx_d = tlb_s_index_i;
        end else if (wr_index) begin
            idx_d = cpu.mtc0_wdata[IDXW-1:0];
        end

        // the exception owns VPN2 but leaves the ASID alone
        if (exc_tlb_we_i)    vpn2_d = exc_badvaddr_i[31:13];
        else if (exec_tlbr)  vpn2_d = tlb_r_entry_i[77:59];
        else if (wr_entryhi) vpn2_d = cpu.mtc0_wdata[31:13];

        if (exec_tlbr)                          asid_d = tlb_r_entry_i[58:51];
        else if (wr_entryhi && !exc_tlb_we_i)   asid_d = cpu.mtc0_wdata[7:0];

        // G of the read entry is replicated into both EntryLo registers
        if (exec_tlbr) begin
            lo0_d = {tlb_r_entry_i[49:25], tlb_r_entry_i[50]};
            lo1_d = {tlb_r_entry_i[24:0],  tlb_r_entry_i[50]};
        end else begin
            if (wr_lo0) lo0_d = cpu.mtc0_wdata[25:0];
            if (wr_lo1) lo1_d = cpu.mtc0_wdata[25:0];
        end
    end

`ifdef TLB_WIRED_EN
    logic [IDXW-1:0] wired_q, wired_d;
    logic            wr_wired;

    assign wr_wired = cpu.mtc0_we && (cpu.mtc0_addr == 5'd6);

    // Random counts down to Wired then wraps; writing Wired restarts it
    always_comb begin
        wired_d = wr_wired ? cpu.mtc0_wdata[IDXW-1:0] : wired_q;
        if (wr_wired || (rand_q <= wired_q)) rand_d = RAND_TOP;
        else                                 rand_d = rand_q - 1'b1;
    end

    // Wired register
    always_ff @(posedge clk) begin
        if (reset) wired_q <= '0;
        else       wired_q <= wired_d;
    end
`else
    // Random counts down over the full range and wraps at zero
    always_comb begin
        rand_d = (rand_q == '0) ? RAND_TOP : rand_q - 1'b1;
    end
`endif

    // CP0 register file state
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_p_q <= 1'b0;
            idx_q   <= '0;
            rand_q  <= RAND_TOP;
            vpn2_q  <= '0;
            asid_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
        end else begin
            idx_p_q <= idx_p_d;
            idx_q   <= idx_d;
            rand_q  <= rand_d;
            vpn2_q  <= vpn2_d;
            asid_q  <= asid_d;
            lo0_q   <= lo0_d;
            lo1_q   <= lo1_d;
        end
    end

    // MFC0 read mux; unmapped addresses read as zero
    always_comb begin
        case (cpu.mfc0_addr)
            5'd0:    cpu.mfc0_rdata = {idx_p_q, {(31-IDXW){1'b0}}, idx_q};
            5'd1:    cpu.mfc0_rdata = {{(32-IDXW){1'b0}}, rand_q};
            5'd2:    cpu.mfc0_rdata = {6'b0, lo0_q};
            5'd3:    cpu.mfc0_rdata = {6'b0, lo1_q};
`ifdef TLB_WIRED_EN
            5'd6:    cpu.mfc0_rdata = {{(32-IDXW){1'b0}}, wired_q};
`endif
            5'd10:   cpu.mfc0_rdata = {vpn2_q, 5'b0, asid_q};
            default: cpu.mfc0_rdata = 32'b0;
        endcase
    end

    assign cpu.op_ready   = op_ready;
    assign cpu.op_done    = op_done;
    assign cp0_entryhi_o  = {vpn2_q, 5'b0, asid_q};
    assign tlb_s_vpn2_o   = vpn2_q;
    assign tlb_s_asid_o   = asid_q;
    assign tlb_we_o       = tlb_we;
    assign tlb_w_index_o  = op_q[0] ? rand_q : idx_q;
    assign tlb_w_entry_o  = {vpn2_q, asid_q, lo0_q[0] & lo1_q[0], lo0_q[25:1], lo1_q[25:1]};
    assign tlb_r_index_o  = idx_q;

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Bench for tlb_cp0_ctrl: directed scenarios followed by random traffic.
// Stimulus pushes expected TLB writes and CP0 snapshots into queues; a
// negedge monitor pops and compares them when tlb_we / op_done appear.
`timescale 1ns/1ps
module tb_tlb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_tlb_we;
    logic [31:0] exc_badvaddr;
    logic [31:0] cp0_entryhi;
    logic [18:0] tlb_s_vpn2;
    logic [7:0]  tlb_s_asid;
    logic        tlb_s_found;
    logic [3:0]  tlb_s_index;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [77:0] tlb_w_entry;
    logic [3:0]  tlb_r_index;
    logic [77:0] tlb_r_entry;

    tlb_cp0_ctrl_if bus();

    tlb_cp0_ctrl #(.TLBNUM(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu            (bus),
        .exc_tlb_we_i   (exc_tlb_we),
        .exc_badvaddr_i (exc_badvaddr),
        .cp0_entryhi_o  (cp0_entryhi),
        .tlb_s_vpn2_o   (tlb_s_vpn2),
        .tlb_s_asid_o   (tlb_s_asid),
        .tlb_s_found_i  (tlb_s_found),
        .tlb_s_index_i  (tlb_s_index),
        .tlb_we_o       (tlb_we),
        .tlb_w_index_o  (tlb_w_index),
        .tlb_w_entry_o  (tlb_w_entry),
        .tlb_r_index_o  (tlb_r_index),
        .tlb_r_entry_i  (tlb_r_entry)
    );

    always #10 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [31:0] m_index, m_ehi, m_lo0, m_lo1;
    logic [77:0] m_tlb [16];
    int          rcnt = 0;      // clock edges since reset released
    bit          mem_load;
    bit          end_req;

    typedef struct { int rc; logic [31:0] idx, ehi, lo0, lo1; } done_t;
    typedef struct { int rc; logic [3:0] widx; logic [77:0] ent; } wr_t;
    done_t dq[$];
    wr_t   wq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // TLB storage seen by the DUT
    logic [77:0] tlb_mem [16];
    assign tlb_r_entry = tlb_mem[tlb_r_index];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) tlb_mem[i] <= m_tlb[i];
        end else if (tlb_we) begin
            tlb_mem[tlb_w_index] <= tlb_w_entry;
        end
    end

    always @(posedge clk) begin
        if (reset) rcnt <= 0;
        else       rcnt <= rcnt + 1;
    end

    function automatic logic [77:0] pack_entry(logic [31:0] ehi, logic [31:0] lo0, logic [31:0] lo1);
        return {ehi[31:13], ehi[7:0], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
    endfunction

    function automatic logic [31:0] ehi_fmt(logic [31:0] v);
        return {v[31:13], 5'b0, v[7:0]};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    bit seen_reset = 1'b0;

    always @(negedge clk) begin
        done_t d;
        wr_t   w;
        #1;
        if (reset) begin
            seen_reset = 1'b1;
            chk("ready_in_reset", 80'(bus.op_ready), 80'(0));
            chk("we_in_reset",    80'(tlb_we),       80'(0));
            chk("done_in_reset",  80'(bus.op_done),  80'(0));
        end else begin
            bus.mfc0_addr = 5'd1; #1;
            chk("random", 80'(bus.mfc0_rdata), 80'(15 - (rcnt % 16)));
            if (seen_reset) begin
                seen_reset = 1'b0;
                bus.mfc0_addr = 5'd0; #1;
                chk("index_after_reset", 80'(bus.mfc0_rdata), 80'(0));
                chk("ready_after_reset", 80'(bus.op_ready), 80'(1));
            end
            if (tlb_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_tlb_we", 80'(1), 80'(0));
                end else begin
                    w = wq.pop_front();
                    chk("we_cycle",  80'(rcnt),        80'(w.rc));
                    chk("w_index",   80'(tlb_w_index), 80'(w.widx));
                    chk("w_entry",   80'(tlb_w_entry), 80'(w.ent));
                end
            end
            if (bus.op_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_op_done", 80'(1), 80'(0));
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", 80'(rcnt), 80'(d.rc));
                    bus.mfc0_addr = 5'd0;  #1; chk("index",   80'(bus.mfc0_rdata), 80'(d.idx));
                    bus.mfc0_addr = 5'd10; #1; chk("entryhi", 80'(bus.mfc0_rdata), 80'(d.ehi));
                    bus.mfc0_addr = 5'd2;  #1; chk("lo0",     80'(bus.mfc0_rdata), 80'(d.lo0));
                    bus.mfc0_addr = 5'd3;  #1; chk("lo1",     80'(bus.mfc0_rdata), 80'(d.lo1));
                    bus.mfc0_addr = 5'd4;  #1; chk("unmapped_rd", 80'(bus.mfc0_rdata), 80'(0));
                    chk("cp0_entryhi", 80'(cp0_entryhi), 80'(d.ehi));
                    chk("s_vpn2",      80'(tlb_s_vpn2),  80'(d.ehi[31:13]));
                    chk("s_asid",      80'(tlb_s_asid),  80'(d.ehi[7:0]));
                    chk("r_index",     80'(tlb_r_index), 80'(d.idx[3:0]));
                end
            end
            if (end_req) begin
                chk("done_queue_empty", 80'(dq.size()), 80'(0));
                chk("write_queue_empty", 80'(wq.size()), 80'(0));
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic model_reset();
        m_index = 32'h0; m_ehi = 32'h0; m_lo0 = 32'h0; m_lo1 = 32'h0;
    endtask

    // one idle cycle with optional MTC0 and/or exception commit; starts at a negedge
    task automatic idle(input bit we, input logic [4:0] a, input logic [31:0] dat,
                        input bit ex, input logic [31:0] bad);
        bus.mtc0_we = we; bus.mtc0_addr = a; bus.mtc0_wdata = dat;
        exc_tlb_we = ex;  exc_badvaddr = bad;
        if (ex)                     m_ehi = {bad[31:13], 5'b0, m_ehi[7:0]};
        else if (we && a == 5'd10)  m_ehi = ehi_fmt(dat);
        if (we && a == 5'd0) m_index = {m_index[31], 27'b0, dat[3:0]};
        if (we && a == 5'd2) m_lo0 = {6'b0, dat[25:0]};
        if (we && a == 5'd3) m_lo1 = {6'b0, dat[25:0]};
        @(negedge clk);
        bus.mtc0_we = 1'b0; exc_tlb_we = 1'b0;
    endtask

    // one TLB instruction, optionally with MTC0/exception landing in its EXEC cycle
    task automatic do_op(input logic [1:0] t, input bit mw, input logic [4:0] ma,
                         input logic [31:0] md, input bit ex, input logic [31:0] bad,
                         input bit sf, input logic [3:0] si);
        int k;
        logic [77:0] ent;
        logic [3:0]  widx;
        if (!bus.op_ready) begin
            $display("FAIL op_ready_wait: got 0 expected 1 (t=%0t)", $time);
            $fatal(1);
        end
        k = rcnt;
        bus.op_valid = 1'b1; bus.op_type = t;
        tlb_s_found = sf; tlb_s_index = si;
        case (t)
            2'd0: m_index = sf ? {28'b0, si} : {1'b1, 27'b0, m_index[3:0]};
            2'd1: begin
                ent   = m_tlb[m_index[3:0]];
                m_ehi = {ent[77:59], 5'b0, ent[58:51]};
                m_lo0 = {6'b0, ent[49:25], ent[50]};
                m_lo1 = {6'b0, ent[24:0],  ent[50]};
            end
            default: begin
                widx = (t == 2'd2) ? m_index[3:0] : 4'(15 - ((k + 1) % 16));
                ent  = pack_entry(m_ehi, m_lo0, m_lo1);
                m_tlb[widx] = ent;
                wq.push_back('{k + 1, widx, ent});
            end
        endcase
        if (ex)                                   m_ehi = {bad[31:13], 5'b0, m_ehi[7:0]};
        else if (mw && ma == 5'd10 && t != 2'd1)  m_ehi = ehi_fmt(md);
        if (mw && ma == 5'd0 && t != 2'd0)        m_index = {m_index[31], 27'b0, md[3:0]};
        if (mw && ma == 5'd2 && t != 2'd1)        m_lo0 = {6'b0, md[25:0]};
        if (mw && ma == 5'd3 && t != 2'd1)        m_lo1 = {6'b0, md[25:0]};
        dq.push_back('{k + 2, m_index, m_ehi, m_lo0, m_lo1});
        @(negedge clk);   // EXEC: op_valid kept high, must not be re-accepted
        bus.mtc0_we = mw; bus.mtc0_addr = ma; bus.mtc0_wdata = md;
        exc_tlb_we = ex;  exc_badvaddr = bad;
        @(negedge clk);   // DONE
        bus.mtc0_we = 1'b0; exc_tlb_we = 1'b0; bus.op_valid = 1'b0;
        @(negedge clk);   // back in IDLE
    endtask

    logic [4:0] addr_tbl [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd10, 5'd4};

    initial begin
        logic [95:0] r96;
        reset = 1'b1; mem_load = 1'b1; end_req = 1'b0;
        bus.op_valid = 1'b0; bus.op_type = 2'd0;
        bus.mtc0_we = 1'b0; bus.mtc0_addr = 5'd0; bus.mtc0_wdata = 32'h0;
        exc_tlb_we = 1'b0; exc_badvaddr = 32'h0;
        tlb_s_found = 1'b0; tlb_s_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            r96 = {$urandom, $urandom, $urandom};
            m_tlb[i] = r96[77:0];
        end
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0; mem_load = 1'b0;
        repeat (20) @(negedge clk);   // Random walks 15..0 and wraps

        // write EntryHi/Lo0/Lo1/Index, then TLBWI, TLBR
        idle(1'b1, 5'd10, 32'h12346005, 1'b0, 32'h0);
        idle(1'b1, 5'd2,  32'h00000147, 1'b0, 32'h0);
        idle(1'b1, 5'd3,  32'h00000187, 1'b0, 32'h0);
        idle(1'b1, 5'd0,  32'h00000003, 1'b0, 32'h0);
        do_op(2'd2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0);
        idle(1'b1, 5'd10, 32'h0, 1'b0, 32'h0);
        do_op(2'd1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0);
        // TLBP hit then miss; TLBP beats a simultaneous MTC0 Index
        do_op(2'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd9);
        do_op(2'd0, 1'b1, 5'd0, 32'h5, 1'b0, 32'h0, 1'b0, 4'd2);
        // TLBR with an exception commit on the same edge
        do_op(2'd1, 1'b1, 5'd10, 32'hFFFFFFFF, 1'b1, 32'hABCDE000, 1'b0, 4'd0);
        // TLBWR
        do_op(2'd3, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0);

        // reset during the EXEC cycle of a TLBWI: no write, back to IDLE
        bus.op_valid = 1'b1; bus.op_type = 2'd2;
        @(negedge clk);
        reset = 1'b1; bus.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++)
                idle($urandom_range(0, 1) == 1, addr_tbl[$urandom_range(0, 5)], $urandom,
                     $urandom_range(0, 7) == 0, $urandom);
            do_op(2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  addr_tbl[$urandom_range(0, 5)], $urandom,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        end_req = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tlb_cp0_ctrl.md
Name: tlb_cp0_ctrl

Overview:
Initiator side of the TLB's search/read/write ports, plus the CP0 TLB register file (Index, Random, EntryLo0, EntryLo1, EntryHi).
- Sequences TLBP, TLBR, TLBWI and TLBWR from the WB/exception stage.
- Owns the EntryHi ASID used by the address-translation logic.
- Executes one TLB instruction at a time through a three-state FSM with a valid/ready handshake and a done pulse.

Parameters:
TLBNUM, 16, number of TLB entries; IDXW = $clog2(TLBNUM) is derived.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
op_valid  input  1  TLB instruction request
op_type  input  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_ready  output  1  controller idle, accepts op
op_done  output  1  one-cycle pulse; CP0 results visible this cycle
mtc0_we  input  1  CP0 write strobe
mtc0_addr  input  5  0 Index, 1 Random, 2 EntryLo0, 3 EntryLo1, 10 EntryHi (6 Wired, optional feature)
mtc0_wdata  input  32  CP0 write data
mfc0_addr  input  5  CP0 read address
mfc0_rdata  output  32  combinational CP0 read data; unknown address reads 0
exc_tlb_we  input  1  TLB exception commit; loads EntryHi VPN2
exc_badvaddr  input  32  faulting virtual address
cp0_entryhi  output  32  current EntryHi
tlb_s_vpn2  output  19  search VPN2 = EntryHi[31:13]
tlb_s_asid  output  8  search ASID = EntryHi[7:0]
tlb_s_found  input  1  search hit
tlb_s_index  input  IDXW  search hit index
tlb_we  output  1  TLB write enable
tlb_w_index  output  IDXW  TLB write index
tlb_w_entry  output  78  {vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}
tlb_r_index  output  IDXW  TLB read index = Index[IDXW-1:0]
tlb_r_entry  input  78  read entry, same packing as tlb_w_entry

Behaviour:
- Register formats:
  - Index: bit31 P (read-only), [IDXW-1:0] writable; other bits 0.
  - EntryHi: [31:13] VPN2, [7:0] ASID writable; other bits 0.
  - EntryLo0/1: [25:6] PFN, [5:3] C, [2] D, [1] V, [0] G; [31:26] 0.
  - Random: [IDXW-1:0], read-only.
- Reset: all CP0 registers 0 except Random = TLBNUM-1. FSM in IDLE; op_done=0, tlb_we=0. op_ready = (state==IDLE) && !reset, so it is 0 while reset is high.
- FSM: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE -> EXEC on op_valid && op_ready; op_type is latched at this edge.
  - EXEC and DONE each last exactly 1 cycle. op_done=1 only in DONE.
  - Latency: accept at edge N, op_done high in the cycle after edge N+1. Back-to-back ops run every 3 cycles.
- EXEC actions per op:
  - TLBP: at the end-of-EXEC edge, Index.P <= !tlb_s_found. If found, Index[IDXW-1:0] <= tlb_s_index; otherwise the index field is unchanged.
  - TLBR: at the end-of-EXEC edge, EntryHi <= {vpn2, 5'b0, asid}. EntryLo0 <= {pfn0, c0, d0, v0, g}; EntryLo1 likewise from the odd half. G is copied into both EntryLo registers.
  - TLBWI: tlb_we=1 for the EXEC cycle only; tlb_w_index = Index[IDXW-1:0].
  - TLBWR: as TLBWI, but tlb_w_index = Random value in the EXEC cycle.
  - Write entry fields come from EntryHi/EntryLo0/EntryLo1, with g = EntryLo0.G & EntryLo1.G.
- Random: decrements every cycle; below its lower bound it wraps to TLBNUM-1. The lower bound is 0 without the optional feature. MTC0 writes to Random are ignored.
- EntryHi write priority, same edge: exc_tlb_we > TLBR result > mtc0. exc_tlb_we sets EntryHi[31:13] <= exc_badvaddr[31:13] and keeps the ASID.
- Index write priority: TLBP result > mtc0. A losing mtc0 write is dropped.
- mtc0 is accepted in any FSM state. A write that lands in EXEC affects a TLBWI/TLBWR only if it lands before that EXEC cycle.
- op_valid while not ready: ignored, not queued.
- Reset mid-operation: FSM returns to IDLE; tlb_we and op_done drop in the next cycle. A write in flight on the reset edge is not performed.

Optional Feature:
TLB_WIRED_EN
- Defined: adds the Wired register (CP0 6), [IDXW-1:0], reset 0.
  - Random range becomes [Wired, TLBNUM-1].
  - An MTC0 to Wired also sets Random to TLBNUM-1 on the same edge.
  - If Wired > TLBNUM-1, Random holds TLBNUM-1.
- Undefined: address 6 reads 0, writes are ignored, and Random cycles over 0..TLBNUM-1.

Test Plan:
- Reset, then idle: Random = 15, 14, ..., 0, 15 on successive cycles; op_ready=1; mfc0 Index reads 0x00000000.
- mtc0 EntryHi=0x12346005, Lo0=0x0000_0147, Lo1=0x0000_0187, Index=3, then TLBWI -> in EXEC, tlb_we=1 for one cycle, w_index=3, vpn2=0x091A3, asid=0x05, g=1, pfn0=0x5, c0=0, d0=1, v0=1, pfn1=0x6.
- TLBR with Index=3 after the previous write -> at op_done, EntryHi=0x12346005, Lo0=0x00000147, Lo1=0x00000187.
- TLBP with found=1, s_index=9 -> Index=0x00000009. TLBP with found=0 -> Index=0x80000009 (index field kept).
- TLBR and exc_tlb_we (badvaddr 0xABCDE000) on the same edge -> EntryHi[31:13]=0x55E6F, ASID taken from the TLB read entry.
- TLB_WIRED_EN: mtc0 Wired=12 -> Random=15 next cycle, then cycles 15, 14, 13, 12, 15. TLBWR uses the sampled value, always in 12..15.
